// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side hazard bundle: D-stage operand/destination info in, pipeline
// enables, bubble insert and forwarding selects out.
interface pipe_hazard_ctrl_if;
  logic [4:0] D_Rs;
  logic [4:0] D_Rt;
  logic [1:0] D_TuseRs;
  logic [1:0] D_TuseRt;
  logic       D_RegWrite;
  logic [4:0] D_WAddr;
  logic [1:0] D_Tnew;
  logic       D_MDStart;
  logic       D_MDDiv;
  logic       D_UsesHILO;
  logic       PC_En;
  logic       FD_En;
  logic       DE_Flush;
  logic [1:0] FwdD_Rs;
  logic [1:0] FwdD_Rt;
  logic [1:0] FwdE_Rs;
  logic [1:0] FwdE_Rt;
  logic       FwdM_Rt;
  logic       MD_Busy;

  modport master (
    output D_Rs, D_Rt, D_TuseRs, D_TuseRt, D_RegWrite, D_WAddr, D_Tnew,
           D_MDStart, D_MDDiv, D_UsesHILO,
    input  PC_En, FD_En, DE_Flush, FwdD_Rs, FwdD_Rt, FwdE_Rs, FwdE_Rt,
           FwdM_Rt, MD_Busy
  );

  modport slave (
    input  D_Rs, D_Rt, D_TuseRs, D_TuseRt, D_RegWrite, D_WAddr, D_Tnew,
           D_MDStart, D_MDDiv, D_UsesHILO,
    output PC_En, FD_En, DE_Flush, FwdD_Rs, FwdD_Rt, FwdE_Rs, FwdE_Rt,
           FwdM_Rt, MD_Busy
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/forward scheduler for the 5-stage F/D/E/M/W pipeline with an E/M/W
// destination scoreboard. Define PIPE_HAZ_MD_UNIT_EN for the mult/div busy window.
module pipe_hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  pipe_hazard_ctrl_if.slave hz
);
  localparam logic [3:0] MULT_L = 4'(MULT_CYC);
  localparam logic [3:0] DIV_L  = 4'(DIV_CYC);

  // live = valid && RegWrite && waddr != 0, folded into one bit when loaded
  logic       r_e_live, r_m_live, r_w_live;
  logic [4:0] r_e_waddr, r_m_waddr, r_w_waddr;
  logic [1:0] r_e_tnew, r_m_tnew;
  logic [4:0] r_e_rs, r_e_rt, r_m_rt;

  logic       w_e_hit_rs, w_e_hit_rt, w_m_hit_rs, w_m_hit_rt;
  logic       w_stall_rs, w_stall_rt, w_md_stall, w_md_busy, w_stall;
  logic [1:0] w_fwdd_rs, w_fwdd_rt, w_fwde_rs, w_fwde_rt;
  logic       w_fwdm_rt;

  function automatic logic [1:0] dec2(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Only the youngest matching entry decides; W never stalls (GRF write-first)
  function automatic logic src_stall(input logic [4:0] s, input logic [1:0] tuse,
                                     input logic e_hit, input logic m_hit,
                                     input logic [1:0] e_tnew, input logic [1:0] m_tnew);
    if (tuse == 2'd3 || s == 5'd0) return 1'b0;
    if (e_hit) return e_tnew > tuse;
    return m_hit && (m_tnew > tuse);
  endfunction

  function automatic logic [1:0] fwd_d(input logic e_hit, input logic m_hit,
                                       input logic [1:0] e_tnew, input logic [1:0] m_tnew);
    if (e_hit) return (e_tnew == 2'd0) ? 2'd1 : 2'd0;
    if (m_hit && m_tnew == 2'd0) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [1:0] fwd_e(input logic [4:0] s,
                                       input logic m_live, input logic [4:0] m_waddr,
                                       input logic [1:0] m_tnew,
                                       input logic w_live, input logic [4:0] w_waddr);
    if (s == 5'd0) return 2'd0;
    if (m_live && m_waddr == s && m_tnew == 2'd0) return 2'd2;
    if (w_live && w_waddr == s) return 2'd3;
    return 2'd0;
  endfunction

  assign w_e_hit_rs = r_e_live && (r_e_waddr == hz.D_Rs);
  assign w_e_hit_rt = r_e_live && (r_e_waddr == hz.D_Rt);
  assign w_m_hit_rs = r_m_live && (r_m_waddr == hz.D_Rs);
  assign w_m_hit_rt = r_m_live && (r_m_waddr == hz.D_Rt);

  assign w_stall_rs = src_stall(hz.D_Rs, hz.D_TuseRs, w_e_hit_rs, w_m_hit_rs, r_e_tnew, r_m_tnew);
  assign w_stall_rt = src_stall(hz.D_Rt, hz.D_TuseRt, w_e_hit_rt, w_m_hit_rt, r_e_tnew, r_m_tnew);
  assign w_stall    = ~i_rst & (w_stall_rs | w_stall_rt | w_md_stall);

  assign w_fwdd_rs = fwd_d(w_e_hit_rs, w_m_hit_rs, r_e_tnew, r_m_tnew);
  assign w_fwdd_rt = fwd_d(w_e_hit_rt, w_m_hit_rt, r_e_tnew, r_m_tnew);
  assign w_fwde_rs = fwd_e(r_e_rs, r_m_live, r_m_waddr, r_m_tnew, r_w_live, r_w_waddr);
  assign w_fwde_rt = fwd_e(r_e_rt, r_m_live, r_m_waddr, r_m_tnew, r_w_live, r_w_waddr);
  assign w_fwdm_rt = r_w_live && (r_m_rt != 5'd0) && (r_w_waddr == r_m_rt);

  // Reset forces the idle output set even while the scoreboard is unknown
  assign hz.PC_En    = ~w_stall;
  assign hz.FD_En    = ~w_stall;
  assign hz.DE_Flush = w_stall;
  assign hz.FwdD_Rs  = i_rst ? 2'd0 : w_fwdd_rs;
  assign hz.FwdD_Rt  = i_rst ? 2'd0 : w_fwdd_rt;
  assign hz.FwdE_Rs  = i_rst ? 2'd0 : w_fwde_rs;
  assign hz.FwdE_Rt  = i_rst ? 2'd0 : w_fwde_rt;
  assign hz.FwdM_Rt  = i_rst ? 1'b0 : w_fwdm_rt;
  assign hz.MD_Busy  = i_rst ? 1'b0 : w_md_busy;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_e_live  <= 1'b0;
      r_e_waddr <= 5'd0;
      r_e_tnew  <= 2'd0;
      r_e_rs    <= 5'd0;
      r_e_rt    <= 5'd0;
      r_m_live  <= 1'b0;
      r_m_waddr <= 5'd0;
      r_m_tnew  <= 2'd0;
      r_m_rt    <= 5'd0;
      r_w_live  <= 1'b0;
      r_w_waddr <= 5'd0;
    end else begin
      if (w_stall) begin
        r_e_live  <= 1'b0;
        r_e_waddr <= 5'd0;
        r_e_tnew  <= 2'd0;
        r_e_rs    <= 5'd0;
        r_e_rt    <= 5'd0;
      end else begin
        r_e_live  <= hz.D_RegWrite && (hz.D_WAddr != 5'd0);
        r_e_waddr <= hz.D_WAddr;
        r_e_tnew  <= hz.D_Tnew;
        r_e_rs    <= hz.D_Rs;
        r_e_rt    <= hz.D_Rt;
      end
      r_m_live  <= r_e_live;
      r_m_waddr <= r_e_waddr;
      r_m_tnew  <= dec2(r_e_tnew);
      r_m_rt    <= r_e_rt;
      r_w_live  <= r_m_live;
      r_w_waddr <= r_m_waddr;
    end
  end

`ifdef PIPE_HAZ_MD_UNIT_EN
  logic       r_e_md_start, r_e_md_div;
  logic [3:0] r_md_cnt;

  assign w_md_busy  = (r_md_cnt != 4'd0) || r_e_md_start;
  assign w_md_stall = hz.D_UsesHILO && w_md_busy;

  // Counter loads as the start leaves E, so the window is start cycle + N
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_e_md_start <= 1'b0;
      r_e_md_div   <= 1'b0;
      r_md_cnt     <= 4'd0;
    end else begin
      r_e_md_start <= hz.D_MDStart && !w_stall;
      r_e_md_div   <= hz.D_MDDiv;
      if (r_e_md_start)
        r_md_cnt <= r_e_md_div ? DIV_L : MULT_L;
      else if (r_md_cnt != 4'd0)
        r_md_cnt <= r_md_cnt - 4'd1;
    end
  end
`else
  assign w_md_busy  = 1'b0 & ^{hz.D_MDStart, hz.D_MDDiv, hz.D_UsesHILO, MULT_L, DIV_L};
  assign w_md_stall = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: reset, load-use, branch-use, jal/jr,
// youngest-entry shadowing, store forwarding and the mult/div busy window.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hz();
  pipe_hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (.i_clk(clk), .i_rst(rst), .hz(hz));

  int n_run = 0;
  int n_fail = 0;
  logic [12:0] obs, e;
  assign obs = {hz.PC_En, hz.FD_En, hz.DE_Flush, hz.FwdD_Rs, hz.FwdD_Rt,
                hz.FwdE_Rs, hz.FwdE_Rt, hz.FwdM_Rt, hz.MD_Busy};

  // Expected output vector: stall drives PC_En/FD_En low and DE_Flush high
  function automatic logic [12:0] ex(input int st, input int fdrs, input int fdrt,
                                     input int fers, input int fert, input int fm, input int md);
    logic s;
    s = st[0];
    return {~s, ~s, s, 2'(fdrs), 2'(fdrt), 2'(fers), 2'(fert), fm[0], md[0]};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drv(input int rs, input int tus, input int rt, input int tut, input int we,
                     input int wa, input int tn, input int mds, input int mdd, input int hl);
    hz.D_Rs = 5'(rs);  hz.D_TuseRs = 2'(tus);
    hz.D_Rt = 5'(rt);  hz.D_TuseRt = 2'(tut);
    hz.D_RegWrite = we[0]; hz.D_WAddr = 5'(wa); hz.D_Tnew = 2'(tn);
    hz.D_MDStart = mds[0]; hz.D_MDDiv = mdd[0]; hz.D_UsesHILO = hl[0];
    #1;
  endtask

  task automatic nop();
    drv(0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic flush();
    rst = 1'b1; nop(); tick(); rst = 1'b0; #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv(8 + i, 0, 9, 0, 1, 8 + i, 2, 1, 1, 1);
      tick();
      e = ex(0,0,0,0,0,0,0); n_run++;
      if (obs !== e) begin n_fail++; $display("FAIL rst_hold%0d got %b want %b", i, obs, e); end
    end
    rst = 1'b0; #1;
    e = ex(0,0,0,0,0,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL rst_release got %b want %b", obs, e); end
    nop(); tick();
    e = ex(0,0,0,0,0,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL rst_idle got %b want %b", obs, e); end
  endtask

  task automatic test_load_use();
    flush();
    drv(29, 1, 0, 3, 1, 8, 2, 0, 0, 0);
    e = ex(0,0,0,0,0,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL lu_lw got %b want %b", obs, e); end
    tick();
    drv(8, 1, 9, 1, 1, 10, 1, 0, 0, 0);
    e = ex(1,0,0,0,0,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL lu_stall got %b want %b", obs, e); end
    tick();
    e = ex(0,0,0,0,0,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL lu_release got %b want %b", obs, e); end
    tick(); nop();
    e = ex(0,0,0,3,0,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL lu_fwde_w got %b want %b", obs, e); end
  endtask

  task automatic test_load_branch();
    flush();
    drv(29, 1, 0, 3, 1, 8, 2, 0, 0, 0); tick();
    drv(8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e = ex(1,0,0,0,0,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL lb_stall1 got %b want %b", obs, e); end
    tick();
    e = ex(1,0,0,0,0,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL lb_stall2 got %b want %b", obs, e); end
    tick();
    // load now in W: operand comes through the write-first GRF, no select
    e = ex(0,0,0,0,0,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL lb_release got %b want %b", obs, e); end
  endtask

  task automatic test_alu_branch();
    flush();
    drv(1, 1, 2, 1, 1, 8, 1, 0, 0, 0); tick();
    drv(8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e = ex(1,0,0,0,0,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL ab_stall got %b want %b", obs, e); end
    tick();
    e = ex(0,2,0,0,0,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL ab_fwdd_m got %b want %b", obs, e); end
  endtask

  task automatic test_jal_jr();
    flush();
    drv(0, 3, 0, 3, 1, 31, 0, 0, 0, 0); tick();
    drv(31, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    e = ex(0,1,0,0,0,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL jj_rs got %b want %b", obs, e); end
    drv(0, 3, 31, 0, 0, 0, 0, 0, 0, 0);
    e = ex(0,0,1,0,0,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL jj_rt got %b want %b", obs, e); end
  endtask

  task automatic test_youngest();
    flush();
    drv(1, 1, 2, 1, 1, 9, 1, 0, 0, 0); tick();
    drv(3, 1, 4, 1, 1, 9, 1, 0, 0, 0);
    e = ex(0,0,0,0,0,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL yg_second got %b want %b", obs, e); end
    tick();
    drv(9, 1, 9, 1, 1, 11, 1, 0, 0, 0);
    e = ex(0,0,0,0,0,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL yg_shadow_d got %b want %b", obs, e); end
    tick(); nop();
    e = ex(0,0,0,2,2,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL yg_fwde_m got %b want %b", obs, e); end
  endtask

  task automatic test_store_fwd();
    flush();
    drv(1, 1, 2, 1, 1, 5, 1, 0, 0, 0); tick();
    drv(29, 1, 5, 2, 0, 0, 0, 0, 0, 0);
    e = ex(0,0,0,0,0,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL st_d got %b want %b", obs, e); end
    tick(); nop();
    e = ex(0,0,0,0,2,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL st_fwde got %b want %b", obs, e); end
    tick();
    e = ex(0,0,0,0,0,1,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL st_fwdm got %b want %b", obs, e); end
  endtask

  task automatic test_boundary();
    flush();
    drv(29, 1, 0, 3, 0, 8, 2, 0, 0, 0); tick();
    drv(8, 0, 8, 0, 0, 0, 0, 0, 0, 0);
    e = ex(0,0,0,0,0,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL bd_nowrite got %b want %b", obs, e); end
    flush();
    drv(29, 1, 0, 3, 1, 8, 2, 0, 0, 0); tick();
    drv(8, 3, 0, 3, 0, 0, 0, 0, 0, 0);
    e = ex(0,0,0,0,0,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL bd_tuse3 got %b want %b", obs, e); end
  endtask

  task automatic test_reset_mid_stall();
    flush();
    drv(29, 1, 0, 3, 1, 8, 2, 0, 0, 0); tick();
    drv(8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e = ex(1,0,0,0,0,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL rm_stall got %b want %b", obs, e); end
    rst = 1'b1; #1;
    e = ex(0,0,0,0,0,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL rm_in_reset got %b want %b", obs, e); end
    tick(); rst = 1'b0; #1;
    e = ex(0,0,0,0,0,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL rm_after got %b want %b", obs, e); end
  endtask

`ifdef PIPE_HAZ_MD_UNIT_EN
  task automatic test_md();
    flush();
    drv(1, 1, 2, 1, 0, 0, 0, 1, 1, 1);
    e = ex(0,0,0,0,0,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL md_idle got %b want %b", obs, e); end
    tick();
    drv(0, 3, 0, 3, 1, 3, 1, 0, 0, 1);
    for (int k = 0; k < 11; k++) begin
      e = ex(1,0,0,0,0,0,1); n_run++;
      if (obs !== e) begin n_fail++; $display("FAIL md_div_busy%0d got %b want %b", k, obs, e); end
      tick();
    end
    e = ex(0,0,0,0,0,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL md_div_clear got %b want %b", obs, e); end
    tick();
    drv(1, 1, 2, 1, 0, 0, 0, 1, 0, 1);
    e = ex(0,0,0,0,0,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL md_mult_d got %b want %b", obs, e); end
    tick(); nop();
    for (int k = 0; k < 5; k++) tick();
    e = ex(0,0,0,0,0,0,1); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL md_mult_last got %b want %b", obs, e); end
    tick();
    e = ex(0,0,0,0,0,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL md_mult_done got %b want %b", obs, e); end
  endtask
`else
  task automatic test_md();
    flush();
    drv(1, 1, 2, 1, 0, 0, 0, 1, 1, 1); tick();
    drv(0, 3, 0, 3, 1, 3, 1, 0, 0, 1);
    e = ex(0,0,0,0,0,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL md_off_d got %b want %b", obs, e); end
    tick();
    e = ex(0,0,0,0,0,0,0); n_run++;
    if (obs !== e) begin n_fail++; $display("FAIL md_off_e got %b want %b", obs, e); end
  endtask
`endif

  initial begin
    nop();
    test_reset();
    test_load_use();
    test_load_branch();
    test_alu_branch();
    test_jal_jr();
    test_youngest();
    test_store_fwd();
    test_boundary();
    test_reset_mid_stall();
    test_md();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
